// File: rtl/net_recv_ingress_filter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | net_recv_ingress_filter: classifies MAC rx frames, forwards IPv4/UDP via a  |
// | 2-entry skid buffer and counts forwarded/dropped/length-error frames.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module net_recv_ingress_filter #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [CNT_WIDTH-1:0]       rx_pkt_count,
    output logic [CNT_WIDTH-1:0]       drop_pkt_count,
    output logic [CNT_WIDTH-1:0]       len_err_count
);

    localparam int c_kcnt_w = $clog2(AXIS_KEEP_WIDTH + 1);

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                     r_state;
    logic [1:0]                 r_occ;
    logic [AXIS_DATA_WIDTH-1:0] r_data0, r_data1;
    logic [AXIS_KEEP_WIDTH-1:0] r_keep0, r_keep1;
    logic                       r_last0, r_last1;
    logic [15:0]                r_ip_len;
    logic [15:0]                r_byte_cnt;
    logic [CNT_WIDTH-1:0]       r_rx_cnt, r_drop_cnt, r_len_err_cnt;

    logic                       w_accept, w_hdr_ok, w_push, w_pop;
    logic [c_kcnt_w-1:0]        w_keep_cnt;
    logic [15:0]                w_cnt_base, w_ip_len_cur, w_cnt_next;
    logic [16:0]                w_sum, w_len_exp;
    logic                       w_len_bad;

    assign s_axis_tready = (r_state == DROP) | (r_occ != 2'd2);
    assign w_accept      = s_axis_tvalid & s_axis_tready;

    assign w_hdr_ok = (s_axis_tdata[8*12 +: 8] == 8'h08) &&
                      (s_axis_tdata[8*13 +: 8] == 8'h00) &&
                      (s_axis_tdata[8*14+4 +: 4] == 4'h4) &&
                      (s_axis_tdata[8*23 +: 8] == 8'h11) &&
                      (&s_axis_tkeep[33:0]);

    assign w_push = w_accept & ((r_state == PASS) | ((r_state == HEAD) & w_hdr_ok));
    assign w_pop  = (r_occ != 2'd0) & m_axis_tready;

    always_comb begin
        w_keep_cnt = '0;
        for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
            w_keep_cnt = w_keep_cnt + c_kcnt_w'(s_axis_tkeep[i]);
        end
    end

    // A first beat starts a fresh count, so single-beat frames are length-checked too.
    assign w_cnt_base   = (r_state == HEAD) ? 16'd0 : r_byte_cnt;
    assign w_ip_len_cur = (r_state == HEAD) ? {s_axis_tdata[8*16 +: 8], s_axis_tdata[8*17 +: 8]}
                                            : r_ip_len;
    assign w_sum        = {1'b0, w_cnt_base} + {{(17-c_kcnt_w){1'b0}}, w_keep_cnt};
    assign w_cnt_next   = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    assign w_len_exp    = {1'b0, w_ip_len_cur} + 17'd14;
    assign w_len_bad    = (w_cnt_next == 16'hFFFF) | ({1'b0, w_cnt_next} != w_len_exp);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= HEAD;
            r_ip_len      <= '0;
            r_byte_cnt    <= '0;
            r_rx_cnt      <= '0;
            r_drop_cnt    <= '0;
            r_len_err_cnt <= '0;
        end else begin
            r_rx_cnt <= r_rx_cnt + {{(CNT_WIDTH-1){1'b0}}, (w_pop & r_last0)};
            if (w_push) begin
                r_byte_cnt <= w_cnt_next;
                if (s_axis_tlast && w_len_bad) begin
                    r_len_err_cnt <= r_len_err_cnt + 1'b1;
                end
            end
            if (w_accept) begin
                case (r_state)
                    HEAD: begin
                        if (w_hdr_ok) begin
                            r_ip_len <= w_ip_len_cur;
                            r_state  <= s_axis_tlast ? HEAD : PASS;
                        end else begin
                            r_drop_cnt <= r_drop_cnt + 1'b1;
                            r_state    <= s_axis_tlast ? HEAD : DROP;
                        end
                    end
                    PASS:    r_state <= s_axis_tlast ? HEAD : PASS;
                    DROP:    r_state <= s_axis_tlast ? HEAD : DROP;
                    default: r_state <= HEAD;
                endcase
            end
        end
    end

    // Slot 0 is the buffer head and drives m_axis_* directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_occ   <= 2'd0;
            r_data0 <= '0;
            r_keep0 <= '0;
            r_last0 <= 1'b0;
            r_data1 <= '0;
            r_keep1 <= '0;
            r_last1 <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_data0 <= s_axis_tdata;
                        r_keep0 <= s_axis_tkeep;
                        r_last0 <= s_axis_tlast;
                    end else begin
                        r_data1 <= s_axis_tdata;
                        r_keep1 <= s_axis_tkeep;
                        r_last1 <= s_axis_tlast;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_keep0 <= r_keep1;
                    r_last0 <= r_last1;
                    r_occ   <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_data0 <= s_axis_tdata;
                        r_keep0 <= s_axis_tkeep;
                        r_last0 <= s_axis_tlast;
                    end else begin
                        r_data0 <= r_data1;
                        r_keep0 <= r_keep1;
                        r_last0 <= r_last1;
                        r_data1 <= s_axis_tdata;
                        r_keep1 <= s_axis_tkeep;
                        r_last1 <= s_axis_tlast;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tvalid  = (r_occ != 2'd0);
    assign m_axis_tdata   = r_data0;
    assign m_axis_tkeep   = r_keep0;
    assign m_axis_tlast   = r_last0;
    assign rx_pkt_count   = r_rx_cnt;
    assign drop_pkt_count = r_drop_cnt;
    assign len_err_count  = r_len_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_net_recv_ingress_filter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_net_recv_ingress_filter: scoreboard bench with a frame-level model.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_net_recv_ingress_filter;

    localparam int DW  = 512;
    localparam int KW  = 64;
    localparam int CW  = 32;
    localparam int CKW = 600;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [CW-1:0] rx_pkt_count, drop_pkt_count, len_err_count;

    net_recv_ingress_filter #(.AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .rx_pkt_count(rx_pkt_count), .drop_pkt_count(drop_pkt_count), .len_err_count(len_err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        bit            lat;
        int            acc;
    } beat_t;

    beat_t         sb[$];
    logic [DW-1:0] fd[$];
    logic [KW-1:0] fk[$];
    int total = 0, bad = 0, cyc = 0;
    int pushed = 0, popped = 0;
    bit dropping = 0, rmode = 0;
    int m_rx = 0, m_drop = 0, m_lerr = 0;

    bit            pv = 0, pr = 0;
    logic [DW-1:0] pd;
    logic [KW-1:0] pk;
    logic          pl;

    task automatic check(input string nm, input logic [CKW-1:0] act, input logic [CKW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [KW-1:0] keep_of(input int n);
        logic [KW-1:0] k = '0;
        for (int j = 0; j < KW; j++) if (j < n) k[j] = 1'b1;
        return k;
    endfunction

    function automatic bit ref_classify(input logic [DW-1:0] d, input logic [KW-1:0] k);
        logic [7:0] b [0:63];
        for (int n = 0; n < 64; n++) b[n] = d[8*n +: 8];
        return (b[12] == 8'h08) && (b[13] == 8'h00) && (b[14][7:4] == 4'h4) &&
               (b[23] == 8'h11) && (&k[33:0]);
    endfunction

    // Builds fd/fk and predicts whether the frame is forwarded and flagged for length.
    task automatic build_frame(input int nb, input int last_bytes, input logic [15:0] etype,
                               input logic [3:0] ver, input logic [7:0] proto, input bit match,
                               input logic [15:0] ipl, output bit fwd, output bit lerr);
        logic [DW-1:0] d;
        int            bytes;
        logic [15:0]   ipl_use;
        fd.delete();
        fk.delete();
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < DW/32; j++) d[j*32 +: 32] = $urandom();
            fd.push_back(d);
            fk.push_back(keep_of((b == nb-1) ? last_bytes : 64));
        end
        bytes   = 64*(nb-1) + last_bytes;
        ipl_use = match ? 16'(bytes - 14) : ipl;
        d = fd[0];
        d[8*12 +: 8] = etype[15:8];
        d[8*13 +: 8] = etype[7:0];
        d[8*14 +: 8] = {ver, 4'h5};
        d[8*16 +: 8] = ipl_use[15:8];
        d[8*17 +: 8] = ipl_use[7:0];
        d[8*23 +: 8] = proto;
        fd[0] = d;
        fwd  = ref_classify(fd[0], fk[0]);
        lerr = fwd && ((bytes >= 65535) || (bytes != 14 + int'(ipl_use)));
    endtask

    task automatic check_rdy();
        check("s_tready", CKW'(s_axis_tready), CKW'(dropping || ((pushed - popped) < 2)));
    endtask

    task automatic send_frame(input bit fwd, input bit lerr, input bit lat, input int gap_pct,
                              input int nsend);
        int i = 0, stall = 0;
        bit acc, last;
        while (i < nsend) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk); #1;
                continue;
            end
            last          = (i == fd.size() - 1);
            s_axis_tdata  = fd[i];
            s_axis_tkeep  = fk[i];
            s_axis_tlast  = last;
            s_axis_tvalid = 1'b1;
            check_rdy();
            acc = s_axis_tready;
            if (acc && fwd) sb.push_back('{d: fd[i], k: fk[i], l: last, lat: lat, acc: cyc + 1});
            @(posedge clk); #1;
            if (acc) begin
                stall = 0;
                if (fwd) pushed++;
                if (i == 0 && !fwd) begin
                    m_drop++;
                    dropping = !last;
                end
                if (last) begin
                    dropping = 0;
                    if (fwd && lerr) m_lerr++;
                end
                i++;
            end else begin
                stall++;
                if (stall > 500) begin
                    total++;
                    bad++;
                    $display("FAIL input_stall: tready low for %0d cycles, expected progress", stall);
                    break;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || m_axis_tvalid) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 5000) begin
            bad++;
            $display("FAIL drain: %0d beats still pending, expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, ".rx_pkt_count"}, CKW'(rx_pkt_count), CKW'(m_rx));
        check({tag, ".drop_pkt_count"}, CKW'(drop_pkt_count), CKW'(m_drop));
        check({tag, ".len_err_count"}, CKW'(len_err_count), CKW'(m_lerr));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".m_outputs"}, CKW'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}), '0);
        check({tag, ".counters"}, CKW'({rx_pkt_count, drop_pkt_count, len_err_count}), '0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_axis_tready = rmode ? ($urandom_range(99) < 55) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks hold-while-stalled.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv = 0;
            end else begin
                if (pv && !pr)
                    check("hold_stable", CKW'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
                          CKW'({1'b1, pl, pk, pd}));
                if (m_axis_tvalid && m_axis_tready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got data %0h expected no beat", m_axis_tdata[63:0]);
                    end else begin
                        e = sb.pop_front();
                        check("beat", CKW'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), CKW'({e.l, e.k, e.d}));
                        if (e.lat) check("latency", CKW'(cyc), CKW'(e.acc));
                        popped++;
                        if (e.l) m_rx++;
                    end
                end
                pv = m_axis_tvalid;
                pr = m_axis_tready;
                pd = m_axis_tdata;
                pk = m_axis_tkeep;
                pl = m_axis_tlast;
            end
        end
    end

    initial begin
        bit fwd, lerr, match;
        int nb, lb, kind;
        logic [15:0] et;
        logic [3:0]  ver;
        logic [7:0]  pro;

        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b1;
        check("ready_after_reset", CKW'(s_axis_tready), CKW'(1));
        @(posedge clk); #1;

        // Nominal 8-beat frame, 512 bytes = 14 + 498
        build_frame(8, 64, 16'h0800, 4'h4, 8'h11, 0, 16'd498, fwd, lerr);
        send_frame(fwd, lerr, 1, 0, 8);
        drain();
        check_counts("nominal");

        // IPv6 ethertype dropped, then a valid frame
        build_frame(4, 64, 16'h86DD, 4'h4, 8'h11, 1, 16'd0, fwd, lerr);
        send_frame(fwd, lerr, 0, 0, 4);
        build_frame(3, 40, 16'h0800, 4'h4, 8'h11, 1, 16'd0, fwd, lerr);
        send_frame(fwd, lerr, 0, 0, 3);
        drain();
        check_counts("non_ipv4");

        // 64 back-to-back frames under random backpressure
        rmode = 1;
        for (int f = 0; f < 64; f++) begin
            build_frame(8, 64, 16'h0800, 4'h4, 8'h11, 1, 16'd0, fwd, lerr);
            send_frame(fwd, lerr, 0, 0, 8);
        end
        drain();
        check_counts("backpressure");
        rmode = 0;

        // ip_len 500 against 512 received bytes
        build_frame(8, 64, 16'h0800, 4'h4, 8'h11, 0, 16'd500, fwd, lerr);
        send_frame(fwd, lerr, 0, 0, 8);
        drain();
        check_counts("len_mismatch");

        // Single-beat frames: UDP forwarded, TCP dropped
        build_frame(1, 64, 16'h0800, 4'h4, 8'h11, 0, 16'd50, fwd, lerr);
        send_frame(fwd, lerr, 0, 0, 1);
        build_frame(1, 64, 16'h0800, 4'h4, 8'h06, 0, 16'd50, fwd, lerr);
        send_frame(fwd, lerr, 0, 0, 1);
        drain();
        check_counts("single_beat");

        // Randomized mix of valid and malformed frames with gaps and backpressure
        rmode = 1;
        for (int f = 0; f < 200; f++) begin
            kind = $urandom_range(0, 5);
            nb   = $urandom_range(1, 6);
            lb   = (nb == 1) ? $urandom_range(34, 64) : $urandom_range(1, 64);
            et   = 16'h0800;
            ver  = 4'h4;
            pro  = 8'h11;
            case (kind)
                2: begin et  = 16'($urandom_range(0, 65535)); if (et == 16'h0800) et = 16'h86DD; end
                3: begin ver = 4'($urandom_range(0, 15));     if (ver == 4'h4) ver = 4'h6; end
                4: begin pro = 8'($urandom_range(0, 255));    if (pro == 8'h11) pro = 8'h06; end
                5: begin nb  = 1; lb = $urandom_range(1, 33); end
                default: ;
            endcase
            match = (nb == 1) || ($urandom_range(0, 1) == 1);
            build_frame(nb, lb, et, ver, pro, match, 16'($urandom_range(0, 65535)), fwd, lerr);
            send_frame(fwd, lerr, 0, 20, nb);
        end
        drain();
        check_counts("random");
        rmode = 0;

        // Reset after 3 of 8 beats, then a fresh frame
        build_frame(8, 64, 16'h0800, 4'h4, 8'h11, 1, 16'd0, fwd, lerr);
        send_frame(fwd, lerr, 0, 0, 3);
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_state("mid_reset");
        sb.delete();
        pushed   = 0;
        popped   = 0;
        dropping = 0;
        m_rx     = 0;
        m_drop   = 0;
        m_lerr   = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("ready_after_mid_reset", CKW'(s_axis_tready), CKW'(1));
        build_frame(8, 64, 16'h0800, 4'h4, 8'h11, 1, 16'd0, fwd, lerr);
        send_frame(fwd, lerr, 0, 0, 8);
        drain();
        check_counts("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
